// File: rtl/uart_core.sv
// uart_core: 8N1 UART receiver and transmitter, each buffered by a FIFO.
// RX FIFO is first-word fall-through; TX line is driven from a register.
module uart_core #(
   parameter int C_BAUDRATE    = 115200,
   parameter int C_SYSTEM_FREQ = 50000000,
   parameter int C_FIFO_DEPTH  = 16
) (
   input  logic       Clk,
   input  logic       Resetn,
   input  logic       RX,
   input  logic       rd_uart_en,
   input  logic       Enable_rx,
   output logic [7:0] RX_data,
   output logic       Empty,
   input  logic [7:0] TX_data,
   input  logic       Enable_tx,
   input  logic       wr_uart_en,
   output logic       Full,
   output logic       TX
);

   localparam int BIT_CLKS = C_SYSTEM_FREQ / C_BAUDRATE;
   localparam int CW = $clog2(BIT_CLKS + 1);
   localparam int AW = $clog2(C_FIFO_DEPTH);
   localparam logic [CW-1:0] BIT_END  = CW'(BIT_CLKS - 1);
   localparam logic [CW-1:0] HALF_END = CW'(BIT_CLKS / 2 - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic          rx_meta, rx_sync, rx_prev;
   logic [1:0]    rx_state;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_push, rx_pop, rx_empty, rx_full;
   logic [AW:0]   rx_wp, rx_rp;
   logic [7:0]    rx_mem [C_FIFO_DEPTH];

   logic [1:0]    tx_state;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_shift;
   logic          tx_end, tx_load, tx_push, tx_empty, tx_full;
   logic [AW:0]   tx_wp, tx_rp;
   logic [7:0]    tx_mem [C_FIFO_DEPTH];

   // Receiver: start detection uses the synchronised line and its previous value
   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_meta <= RX;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         unique case (rx_state)
            S_IDLE: begin
               rx_cnt <= '0;
               rx_bit <= '0;
               if (Enable_rx && rx_prev && !rx_sync)
                  rx_state <= S_START;
            end
            S_START: begin
               if (rx_cnt == HALF_END) begin
                  rx_cnt   <= '0;
                  rx_state <= rx_sync ? S_IDLE : S_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (rx_cnt == BIT_END) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7)
                     rx_state <= S_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (rx_cnt == BIT_END) begin
                  rx_cnt   <= '0;
                  rx_state <= S_IDLE;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            default: rx_state <= S_IDLE;
         endcase
      end
   end

   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[AW] != rx_rp[AW]) &&
                     (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
   assign rx_push  = (rx_state == S_STOP) && (rx_cnt == BIT_END) &&
                     rx_sync && !rx_full;
   assign rx_pop   = rd_uart_en && !rx_empty;

   always_ff @(posedge Clk) begin
      if (rx_push)
         rx_mem[rx_wp[AW-1:0]] <= rx_shift;
   end

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end
   end

   assign Empty   = rx_empty;
   assign RX_data = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];

   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[AW] != tx_rp[AW]) &&
                     (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
   assign tx_push  = wr_uart_en && !tx_full;
   assign Full     = tx_full;

   always_ff @(posedge Clk) begin
      if (tx_push)
         tx_mem[tx_wp[AW-1:0]] <= TX_data;
   end

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         tx_wp <= '0;
         tx_rp <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_load) tx_rp <= tx_rp + 1'b1;
      end
   end

   // Loading on the last stop cycle makes back-to-back frames gapless
   assign tx_end  = (tx_cnt == BIT_END);
   assign tx_load = Enable_tx && !tx_empty &&
                    ((tx_state == S_IDLE) ||
                     ((tx_state == S_STOP) && tx_end));

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         TX       <= 1'b1;
      end else if (tx_load) begin
         tx_shift <= tx_mem[tx_rp[AW-1:0]];
         tx_cnt   <= '0;
         tx_bit   <= '0;
         TX       <= 1'b0;
         tx_state <= S_START;
      end else begin
         unique case (tx_state)
            S_IDLE: TX <= 1'b1;
            S_START: begin
               if (tx_end) begin
                  tx_cnt   <= '0;
                  TX       <= tx_shift[0];
                  tx_state <= S_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (tx_end) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     TX       <= 1'b1;
                     tx_state <= S_STOP;
                  end else begin
                     TX       <= tx_shift[1];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx_bit   <= tx_bit + 3'd1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (tx_end) begin
                  tx_cnt   <= '0;
                  tx_state <= S_IDLE;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: tx_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed checks of the uart_core receive/transmit paths.
// 4 MHz / 115200 baud truncates to 34 clocks per bit.
module tb_uart_core;

   localparam int BIT = 34;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_drv;
   logic       loop;
   logic       rx_in;
   logic       rd_en;
   logic       en_rx;
   logic [7:0] rx_data;
   logic       empty;
   logic [7:0] tx_data;
   logic       en_tx;
   logic       wr_en;
   logic       full;
   logic       tx;

   int n_pass = 0;
   int n_total = 0;

   assign rx_in = loop ? tx : rx_drv;

   always #5 clk = ~clk;

   uart_core #(
      .C_BAUDRATE(115200),
      .C_SYSTEM_FREQ(4000000),
      .C_FIFO_DEPTH(16)
   ) dut (
      .Clk(clk),
      .Resetn(rst_n),
      .RX(rx_in),
      .rd_uart_en(rd_en),
      .Enable_rx(en_rx),
      .RX_data(rx_data),
      .Empty(empty),
      .TX_data(tx_data),
      .Enable_tx(en_tx),
      .wr_uart_en(wr_en),
      .Full(full),
      .TX(tx)
   );

   task automatic send_byte(input logic [7:0] b, input logic stop,
                            input logic drop_en);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_drv = fr[i];
         if (i == 1 && drop_en) en_rx = 1'b0;
         repeat (BIT) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   task automatic pop();
      @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      @(negedge clk);
      wr_en = 1'b1;
      tx_data = b;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic tx_capture(input int limit, output logic [7:0] b,
                             output int wait_c, output logic got);
      wait_c = 0;
      b = 8'h00;
      while (tx !== 1'b0 && wait_c < limit) begin
         @(negedge clk);
         wait_c++;
      end
      got = (tx === 1'b0);
      if (got) begin
         repeat (BIT / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            b[i] = tx;
         end
         repeat (BIT) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_total++;
      if (empty !== 1'b1) $display("FAIL rst_empty: got %b expected 1", empty);
      else n_pass++;
      n_total++;
      if (full !== 1'b0) $display("FAIL rst_full: got %b expected 0", full);
      else n_pass++;
      n_total++;
      if (tx !== 1'b1) $display("FAIL rst_tx: got %b expected 1", tx);
      else n_pass++;
      n_total++;
      if (rx_data !== 8'h00) $display("FAIL rst_rxdata: got %h expected 00", rx_data);
      else n_pass++;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_rx_single();
      send_byte(8'h81, 1'b1, 1'b0);
      n_total++;
      if (empty !== 1'b0) $display("FAIL rx1_empty: got %b expected 0", empty);
      else n_pass++;
      n_total++;
      if (rx_data !== 8'h81) $display("FAIL rx1_data: got %h expected 81", rx_data);
      else n_pass++;
      pop();
      n_total++;
      if (empty !== 1'b1) $display("FAIL rx1_pop: got %b expected 1", empty);
      else n_pass++;
      send_byte(8'hC6, 1'b1, 1'b1);
      en_rx = 1'b1;
      n_total++;
      if (rx_data !== 8'hC6 || empty !== 1'b0)
         $display("FAIL rx_en_drop: got %h/%b expected c6/0", rx_data, empty);
      else n_pass++;
      pop();
   endtask

   task automatic test_rx_overflow();
      for (int i = 0; i < 20; i++)
         send_byte(8'(i), 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         n_total++;
         if (empty !== 1'b0 || rx_data !== 8'(i))
            $display("FAIL rx_ovf_%0d: got %h/%b expected %h/0", i, rx_data, empty, 8'(i));
         else n_pass++;
         pop();
      end
      n_total++;
      if (empty !== 1'b1) $display("FAIL rx_ovf_empty: got %b expected 1", empty);
      else n_pass++;
   endtask

   task automatic test_rx_errors();
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (10) @(negedge clk);
      rx_drv = 1'b1;
      repeat (12 * BIT) @(negedge clk);
      n_total++;
      if (empty !== 1'b1) $display("FAIL rx_glitch: got %b expected 1", empty);
      else n_pass++;
      send_byte(8'h5A, 1'b0, 1'b0);
      repeat (2 * BIT) @(negedge clk);
      n_total++;
      if (empty !== 1'b1) $display("FAIL rx_framing: got %b expected 1", empty);
      else n_pass++;
      en_rx = 1'b0;
      send_byte(8'h99, 1'b1, 1'b0);
      repeat (BIT) @(negedge clk);
      en_rx = 1'b1;
      repeat (BIT) @(negedge clk);
      n_total++;
      if (empty !== 1'b1) $display("FAIL rx_disabled: got %b expected 1", empty);
      else n_pass++;
      send_byte(8'h3C, 1'b1, 1'b0);
      n_total++;
      if (empty !== 1'b0 || rx_data !== 8'h3C)
         $display("FAIL rx_recover: got %h/%b expected 3c/0", rx_data, empty);
      else n_pass++;
      pop();
   endtask

   task automatic test_tx_frame();
      logic [9:0] exp;
      int c;
      exp = {1'b1, 8'h55, 1'b0};
      en_tx = 1'b1;
      push(8'h55);
      c = 0;
      while (tx !== 1'b0 && c < 8) begin
         @(negedge clk);
         c++;
      end
      n_total++;
      if (c !== 1) $display("FAIL tx_latency: got %0d expected 1", c);
      else n_pass++;
      c = 0;
      while (tx === 1'b0 && c < 2 * BIT) begin
         @(negedge clk);
         c++;
      end
      n_total++;
      if (c !== BIT) $display("FAIL tx_start_len: got %0d expected %0d", c, BIT);
      else n_pass++;
      repeat (BIT / 2) @(negedge clk);
      for (int i = 1; i < 10; i++) begin
         n_total++;
         if (tx !== exp[i])
            $display("FAIL tx_bit_%0d: got %b expected %b", i, tx, exp[i]);
         else n_pass++;
         repeat (BIT) @(negedge clk);
      end
      n_total++;
      if (tx !== 1'b1) $display("FAIL tx_idle: got %b expected 1", tx);
      else n_pass++;
   endtask

   task automatic test_tx_full();
      logic [7:0] b;
      int w;
      logic got;
      en_tx = 1'b0;
      for (int i = 0; i < 17; i++) begin
         push(8'h10 + 8'(i));
         if (i == 14) begin
            n_total++;
            if (full !== 1'b0) $display("FAIL tx_full15: got %b expected 0", full);
            else n_pass++;
         end
         if (i >= 15) begin
            n_total++;
            if (full !== 1'b1) $display("FAIL tx_full%0d: got %b expected 1", i + 1, full);
            else n_pass++;
         end
      end
      @(negedge clk);
      en_tx = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tx_capture(4 * BIT, b, w, got);
         n_total++;
         if (got !== 1'b1 || b !== 8'h10 + 8'(i))
            $display("FAIL tx_byte_%0d: got %h/%b expected %h/1", i, b, got, 8'h10 + 8'(i));
         else n_pass++;
         if (i > 0) begin
            n_total++;
            if (w !== BIT - BIT / 2)
               $display("FAIL tx_gap_%0d: got %0d expected %0d", i, w, BIT - BIT / 2);
            else n_pass++;
         end
      end
      tx_capture(3 * BIT, b, w, got);
      n_total++;
      if (got !== 1'b0) $display("FAIL tx_17th: got frame %h expected none", b);
      else n_pass++;
   endtask

   task automatic test_loopback();
      int c;
      loop = 1'b1;
      en_tx = 1'b1;
      push(8'hA5);
      push(8'h3C);
      for (int k = 0; k < 2; k++) begin
         c = 0;
         while (empty !== 1'b0 && c < 30 * BIT) begin
            @(negedge clk);
            c++;
         end
         n_total++;
         if (empty !== 1'b0 || rx_data !== (k == 0 ? 8'hA5 : 8'h3C))
            $display("FAIL lb_byte_%0d: got %h/%b expected %h/0", k, rx_data, empty,
                     (k == 0 ? 8'hA5 : 8'h3C));
         else n_pass++;
         pop();
      end
      repeat (2 * BIT) @(negedge clk);
      n_total++;
      if (empty !== 1'b1) $display("FAIL lb_empty: got %b expected 1", empty);
      else n_pass++;
      loop = 1'b0;
   endtask

   task automatic test_mid_reset();
      int lows;
      send_byte(8'h42, 1'b1, 1'b0);
      en_tx = 1'b0;
      for (int i = 0; i < 16; i++) push(8'(i));
      n_total++;
      if (full !== 1'b1 || empty !== 1'b0)
         $display("FAIL mr_pre: got full %b empty %b expected 1/0", full, empty);
      else n_pass++;
      en_tx = 1'b1;
      repeat (10) @(negedge clk);
      n_total++;
      if (tx !== 1'b0) $display("FAIL mr_tx_busy: got %b expected 0", tx);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if (empty !== 1'b1) $display("FAIL mr_empty: got %b expected 1", empty);
      else n_pass++;
      n_total++;
      if (full !== 1'b0) $display("FAIL mr_full: got %b expected 0", full);
      else n_pass++;
      n_total++;
      if (tx !== 1'b1) $display("FAIL mr_tx: got %b expected 1", tx);
      else n_pass++;
      n_total++;
      if (rx_data !== 8'h00) $display("FAIL mr_rxdata: got %h expected 00", rx_data);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      lows = 0;
      for (int i = 0; i < 12 * BIT; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      n_total++;
      if (lows !== 0) $display("FAIL mr_tx_quiet: got %0d low cycles expected 0", lows);
      else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0;
      rx_drv = 1'b1;
      loop = 1'b0;
      rd_en = 1'b0;
      en_rx = 1'b1;
      tx_data = 8'h00;
      en_tx = 1'b0;
      wr_en = 1'b0;
      test_reset();
      test_rx_single();
      test_rx_overflow();
      test_rx_errors();
      test_tx_frame();
      test_tx_full();
      test_loopback();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
